// File: rtl/mole_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mole_round_ctrl
//  Description : Whack-a-mole round sequencer. Lights one mole at a time at a
//                random hole, times each window, scores toggle-hits and
//                counts down the moles remaining in a fixed-length round.
//  Revision    : 1.0 - initial release
// ============================================================================
module mole_round_ctrl #(
    parameter int MOLE_ON_TICKS = 800,
    parameter int GAP_TICKS     = 200,
    parameter int ROUND_MOLES   = 20,
    parameter int SCORE_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_clean,
    input  logic [8:0]         sw_clean,
    input  logic [3:0]         rand_val,
    output logic [8:0]         mole_onehot,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         moles_left,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               game_over,
    output logic               busy
);

    localparam int c_TICK_MAX = (MOLE_ON_TICKS > GAP_TICKS) ? MOLE_ON_TICKS : GAP_TICKS;
    localparam int c_TIMER_W  = (c_TICK_MAX > 1) ? $clog2(c_TICK_MAX) : 1;

    localparam logic [c_TIMER_W-1:0] c_GAP_LAST  = c_TIMER_W'(GAP_TICKS - 1);
    localparam logic [c_TIMER_W-1:0] c_SHOW_LAST = c_TIMER_W'(MOLE_ON_TICKS - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE = c_TIMER_W'(1);
    localparam logic [7:0]           c_ROUND     = 8'(ROUND_MOLES);
    localparam logic [SCORE_W-1:0]   c_SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0]   c_SCORE_ONE = SCORE_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_SHOW = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_TIMER_W-1:0] r_timer;
    logic                 r_btn_prev;
    logic [8:0]           r_sw_prev;
    logic [8:0]           r_mole;
    logic [SCORE_W-1:0]   r_score;
    logic [7:0]           r_moles_left;
    logic                 r_hit;
    logic                 r_miss;
    logic                 r_game_over;
    logic                 r_busy;

    logic                 w_btn_rise;
    logic [8:0]           w_sw_tog;
    logic [3:0]           w_pos_next;
    logic                 w_hit;

    assign w_btn_rise = btn_clean & ~r_btn_prev;
    assign w_sw_tog   = sw_clean ^ r_sw_prev;
    // Fold the 4-bit random value onto the nine holes.
    assign w_pos_next = (rand_val < 4'd9) ? rand_val : (rand_val - 4'd9);
    // The lit mole register already holds the latched position one-hot, so
    // any toggle overlapping it is a hit (several toggles still count once).
    assign w_hit      = |(w_sw_tog & r_mole);

    // Edge-detect history, tracked every cycle regardless of state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_prev <= 1'b0;
            r_sw_prev  <= 9'd0;
        end else begin
            r_btn_prev <= btn_clean;
            r_sw_prev  <= sw_clean;
        end
    end

    // Round sequencer with registered outputs; btn_rise outranks hit/timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_mole       <= 9'd0;
            r_score      <= '0;
            r_moles_left <= 8'd0;
            r_hit        <= 1'b0;
            r_miss       <= 1'b0;
            r_game_over  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_hit  <= 1'b0;
            r_miss <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_btn_rise) begin
                        r_score      <= '0;
                        r_moles_left <= c_ROUND;
                        r_timer      <= '0;
                        r_mole       <= 9'd0;
                        r_game_over  <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (w_btn_rise) begin
                        r_timer <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_timer == c_GAP_LAST) begin
                        r_mole       <= 9'd1 << w_pos_next;
                        r_timer      <= '0;
                        r_moles_left <= r_moles_left - 8'd1;
                        r_state      <= S_SHOW;
                    end else begin
                        r_timer <= r_timer + c_TIMER_ONE;
                    end
                end
                S_SHOW: begin
                    if (w_btn_rise) begin
                        r_mole  <= 9'd0;
                        r_timer <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_hit || (r_timer == c_SHOW_LAST)) begin
                        if (w_hit) begin
                            r_hit <= 1'b1;
                            if (r_score != c_SCORE_MAX) begin
                                r_score <= r_score + c_SCORE_ONE;
                            end
                        end else begin
                            r_miss <= 1'b1;
                        end
                        r_mole  <= 9'd0;
                        r_timer <= '0;
                        if (r_moles_left == 8'd0) begin
                            r_busy      <= 1'b0;
                            r_game_over <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end else begin
                        r_timer <= r_timer + c_TIMER_ONE;
                    end
                end
                default: begin
                    r_mole  <= 9'd0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mole_onehot = r_mole;
    assign score       = r_score;
    assign moles_left  = r_moles_left;
    assign hit_pulse   = r_hit;
    assign miss_pulse  = r_miss;
    assign game_over   = r_game_over;
    assign busy        = r_busy;

endmodule
`default_nettype wire
